pm_loader: RTL and testbench

//  Loads the microprocessor's program memory: the writer for the sequencer's read port.

---
 rtl/pm_loader_pkg.sv | 29 ++
 rtl/pm_loader_timeout.sv | 32 +++
 rtl/pm_loader.sv | 175 +++++++++++++++++
 tb/tb_pm_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_loader_pkg.sv
// Shared types and defaults for the program-memory loader: state encoding,
// default widths, the frame sync marker and small state-class helpers.
package pm_loader_pkg;

  localparam int          DEF_ADDR_W         = 8;
  localparam int          DEF_DATA_W         = 8;
  localparam int          DEF_TIMEOUT_CYCLES = 1024;
  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } ldr_state_t;

  // States in which the loader is willing to accept a byte from the stream.
  function automatic logic is_rx_state(input ldr_state_t s);
    return (s == IDLE) || (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

  // States inside a frame, where a stalled sender must eventually time out.
  function automatic logic is_timed_state(input ldr_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/pm_loader_timeout.sv
// Idle-cycle watchdog. Counts consecutive enabled cycles without a clear and
// flags expiry on the cycle that would be the TIMEOUT_CYCLES-th idle cycle.
// A clear on that same cycle wins, so a late-but-in-time byte is accepted.
module pm_loader_timeout
  import pm_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_idle;

  // Idle counter: held at zero when disabled or cleared, saturates at the last idle value.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr || !i_en) begin
      r_idle <= '0;
    end else if (r_idle != LAST_IDLE) begin
      r_idle <= r_idle + CW'(1);
    end
  end

  assign o_expired = i_en && !i_clr && (r_idle == LAST_IDLE);

endmodule

// File: rtl/pm_loader.sv
// Program-memory loader. Receives a framed byte stream (sync, length, data,
// checksum) over valid/ready and writes one instruction per data byte into the
// program RAM write port. The processor is held in reset until a frame whose
// checksum is good has been fully received.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                DATA_W         = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE      = DATA_W'(DEF_SYNC_BYTE),
  parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_pm_wr_addr,
  output logic [DATA_W-1:0] o_pm_wr_data,
  output logic              o_pm_wren,
  output logic              o_cpu_reset,
  output logic              o_load_done,
  output logic              o_load_error
);

  ldr_state_t r_state;
  ldr_state_t w_next;

  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_sum;

  logic              r_rx_ready;
  logic              r_pm_wren;
  logic [ADDR_W-1:0] r_pm_wr_addr;
  logic [DATA_W-1:0] r_pm_wr_data;
  logic              r_cpu_reset;
  logic              r_load_done;
  logic              r_load_error;

  logic              w_xfer;
  logic              w_timed;
  logic              w_expired;
  logic              w_wr_fire;
  logic              w_sum_ok;
  logic [DATA_W-1:0] w_sum_next;
  logic [ADDR_W-1:0] w_len_last;

  // A byte moves only when the registered ready meets the sender's valid.
  assign w_xfer     = i_rx_valid && r_rx_ready;
  assign w_timed    = is_timed_state(r_state);
  assign w_sum_next = r_sum + i_rx_data;
  assign w_sum_ok   = (w_sum_next == '0);
  // The length byte is turned into the index of the last data byte; zero means a full memory.
  assign w_len_last = (i_rx_data == '0) ? '1 : ADDR_W'(i_rx_data - DATA_W'(1));

  pm_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_xfer || i_start),
    .i_en      (w_timed),
    .o_expired (w_expired)
  );

  // Next-state and write-strobe decode; a transfer always beats a simultaneous timeout.
  always_comb begin
    w_next    = r_state;
    w_wr_fire = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer && (i_rx_data == SYNC_BYTE)) begin
          w_next = LEN;
        end
      end
      LEN: begin
        if (w_xfer) begin
          w_next = DATA;
        end else if (w_expired) begin
          w_next = ERR;
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_wr_fire = 1'b1;
          if (r_cnt == r_last) begin
            w_next = CSUM;
          end
        end else if (w_expired) begin
          w_next = ERR;
        end
      end
      CSUM: begin
        if (w_xfer) begin
          w_next = w_sum_ok ? DONE : ERR;
        end else if (w_expired) begin
          w_next = ERR;
        end
      end
      DONE, ERR: begin
        w_next = r_state;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register; start aborts any frame in progress and waits for a new sync byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else if (i_start) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame datapath: last-index, write address counter and running checksum.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_cnt  <= '0;
      r_last <= '0;
      r_sum  <= '0;
    end else if ((r_state == LEN) && w_xfer) begin
      r_last <= w_len_last;
      r_cnt  <= '0;
      r_sum  <= '0;
    end else if ((r_state == DATA) && w_xfer) begin
      r_cnt  <= r_cnt + ADDR_W'(1);
      r_sum  <= w_sum_next;
    end
  end

  // Registered outputs: one-cycle write strobe, handshake ready, sticky status and CPU reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_ready   <= 1'b0;
      r_pm_wren    <= 1'b0;
      r_pm_wr_addr <= '0;
      r_pm_wr_data <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else if (i_start) begin
      r_rx_ready   <= 1'b0;
      r_pm_wren    <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_rx_ready   <= is_rx_state(w_next);
      r_pm_wren    <= w_wr_fire;
      if (w_wr_fire) begin
        r_pm_wr_addr <= r_cnt;
        r_pm_wr_data <= i_rx_data;
      end
      r_cpu_reset  <= r_cpu_reset && (w_next != DONE);
      r_load_done  <= r_load_done || (w_next == DONE);
      r_load_error <= r_load_error || (w_next == ERR);
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_pm_wren    = r_pm_wren;
  assign o_pm_wr_addr = r_pm_wr_addr;
  assign o_pm_wr_data = r_pm_wr_data;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: a table of per-cycle vectors for the
// short frames, plus hand-written sequences for timeout, full-length frames
// and mid-frame abort.
module tb_pm_loader;

  localparam int TIMEOUT = 1024;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       wren;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       err;
    logic       cpuRst;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] pmWrAddr;
  logic [7:0] pmWrData;
  logic       pmWren;
  logic       cpuReset;
  logic       loadDone;
  logic       loadError;

  int testsRun;
  int testsFailed;
  int wrenCount;
  vec_t vecs[$];

  pm_loader #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .o_rx_ready   (rxReady),
    .o_pm_wr_addr (pmWrAddr),
    .o_pm_wr_data (pmWrData),
    .o_pm_wren    (pmWren),
    .o_cpu_reset  (cpuReset),
    .o_load_done  (loadDone),
    .o_load_error (loadError)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic w, input logic [7:0] a, input logic [7:0] wd,
                              input logic rdy, input logic dn, input logic er, input logic cr);
    vec_t r;
    r.start = s;  r.valid = v;  r.data = d;
    r.wren = w;   r.addr = a;   r.wdata = wd;
    r.ready = rdy; r.done = dn; r.err = er; r.cpuRst = cr;
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
    start   = s;
    rxValid = v;
    rxData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, ".ready"},  32'(rxReady),   32'(v.ready));
    checkOutput({tag, ".wren"},   32'(pmWren),    32'(v.wren));
    checkOutput({tag, ".done"},   32'(loadDone),  32'(v.done));
    checkOutput({tag, ".err"},    32'(loadError), 32'(v.err));
    checkOutput({tag, ".cpuRst"}, 32'(cpuReset),  32'(v.cpuRst));
    if (v.wren) begin
      checkOutput({tag, ".addr"},  32'(pmWrAddr), 32'(v.addr));
      checkOutput({tag, ".wdata"}, 32'(pmWrData), 32'(v.wdata));
    end
  endtask

  task automatic startPulse();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset   = 1'b1;
    start   = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;

    // Good frame: 11+22+33 = 66, so the closing checksum byte is 9A.
    vecs.push_back(mk(0,1,8'hA5, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h03, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h11, 1,8'h00,8'h11, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h22, 1,8'h01,8'h22, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h33, 1,8'h02,8'h33, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h9A, 0,8'h00,8'h00, 0,1,0,0));
    vecs.push_back(mk(0,0,8'h00, 0,8'h00,8'h00, 0,1,0,0));
    // Start clears the flags, then a frame with a bad checksum.
    vecs.push_back(mk(1,0,8'h00, 0,8'h00,8'h00, 0,0,0,1));
    vecs.push_back(mk(0,0,8'h00, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'hA5, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h02, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h01, 1,8'h00,8'h01, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h02, 1,8'h01,8'h02, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h00, 0,8'h00,8'h00, 0,0,1,1));
    vecs.push_back(mk(0,1,8'hA5, 0,8'h00,8'h00, 0,0,1,1));
    vecs.push_back(mk(1,0,8'h00, 0,8'h00,8'h00, 0,0,0,1));
    vecs.push_back(mk(0,0,8'h00, 0,8'h00,8'h00, 1,0,0,1));
    // Garbage before the sync byte is ignored.
    vecs.push_back(mk(0,1,8'h00, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'hFF, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h5A, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'hA5, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h01, 0,8'h00,8'h00, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h7E, 1,8'h00,8'h7E, 1,0,0,1));
    vecs.push_back(mk(0,1,8'h82, 0,8'h00,8'h00, 0,1,0,0));

    // Reset state, held for two cycles.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("rst.ready",  32'(rxReady),   32'd0);
      checkOutput("rst.cpuRst", 32'(cpuReset),  32'd1);
      checkOutput("rst.wren",   32'(pmWren),    32'd0);
      checkOutput("rst.done",   32'(loadDone),  32'd0);
      checkOutput("rst.err",    32'(loadError), 32'd0);
      checkOutput("rst.addr",   32'(pmWrAddr),  32'd0);
      checkOutput("rst.wdata",  32'(pmWrData),  32'd0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst.readyAfter", 32'(rxReady), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].data);
      checkVec(vecs[i], i);
    end

    // Timeout: one data byte, then silence until expiry.
    startPulse();
    wrenCount = 0;
    applyStimulus(1'b0, 1'b1, 8'hA5); wrenCount += int'(pmWren);
    applyStimulus(1'b0, 1'b1, 8'h04); wrenCount += int'(pmWren);
    applyStimulus(1'b0, 1'b1, 8'hAA); wrenCount += int'(pmWren);
    for (int i = 1; i <= TIMEOUT; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      wrenCount += int'(pmWren);
      if (i == TIMEOUT - 1) checkOutput("to.errBefore", 32'(loadError), 32'd0);
      if (i == TIMEOUT) begin
        checkOutput("to.errAt",  32'(loadError), 32'd1);
        checkOutput("to.cpuRst", 32'(cpuReset),  32'd1);
        checkOutput("to.ready",  32'(rxReady),   32'd0);
      end
    end
    checkOutput("to.wrenCount", 32'(wrenCount), 32'd1);

    // A byte arriving on the timeout cycle itself is accepted.
    startPulse();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h04);
    for (int i = 1; i < TIMEOUT; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("tw.err",  32'(loadError), 32'd0);
    checkOutput("tw.write", {15'd0, pmWren, pmWrAddr, pmWrData}, {15'd0, 1'b1, 8'h00, 8'h55});

    // Full-length frame: LEN 00 means 256 bytes; sum of 0..255 is 0x80 mod 256.
    startPulse();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i));
      checkOutput($sformatf("full.write%0d", i), {15'd0, pmWren, pmWrAddr, pmWrData},
                  {15'd0, 1'b1, 8'(i), 8'(i)});
    end
    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("full.done",   32'(loadDone),  32'd1);
    checkOutput("full.err",    32'(loadError), 32'd0);
    checkOutput("full.cpuRst", 32'(cpuReset),  32'd0);

    // Abort mid-DATA: no further writes, next frame rewrites from address 0.
    startPulse();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h44);
    wrenCount = 0;
    applyStimulus(1'b1, 1'b1, 8'h44); wrenCount += int'(pmWren);
    checkOutput("abort.cpuRst", 32'(cpuReset), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h44);
      wrenCount += int'(pmWren);
    end
    checkOutput("abort.noWrites", 32'(wrenCount), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h77);
    checkOutput("abort.rewrite", {15'd0, pmWren, pmWrAddr, pmWrData}, {15'd0, 1'b1, 8'h00, 8'h77});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
